wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage: the only driver of the register file write port.
//  Merges ALU results and load-unit return data into one write per cycle.
//  Load data is buffered in a small FIFO, byte/half-aligned and sign/zero-extended.
//  An anti-starvation counter guarantees that loads make forward progress.
// PARAMETERS
//  LD_FIFO_DEPTH  2  load-return FIFO entries (power of 2, >=2)
//  STARVE_LIMIT   4  cycles a load FIFO head may lose arbitration before it is forced to win (>=1)
// PORTS
//  clk            in   1   clock
//  reset          in   1   asynchronous, active-high reset
//  alu_valid      in   1   ALU result present
//  alu_ready      out  1   ALU result accepted this cycle (when alu_valid=1)
//  alu_rd         in   5   ALU destination register
//  alu_data       in   32  ALU result
//  ld_valid       in   1   load return present
//  ld_ready       out  1   load FIFO can accept (= !full)
//  ld_rd          in   5   load destination register
//  ld_funct3      in   3   RV32I load type
//  ld_addr_lo     in   2   effective address [1:0]
//  ld_rdata       in   32  raw aligned-word memory data
//  rf_write_enable out 1   to register file write_enable
//  rf_rd_address  out  5   to register file rd_address
//  rf_write_data  out  32  to register file write_data
// BEHAVIOUR
//  - Reset: all rf_* outputs 0, FIFO empty, starve_cnt 0, ld_ready 1.
//    Reset mid-operation discards buffered loads; no write is issued for them.
//  - rf_* outputs are registered. An ALU result accepted at edge N is visible
//    on rf_* in the cycle after edge N. A load is enqueued at edge N, is
//    eligible at N+1 at the earliest, and is visible after edge N+1.
//  - A load is never bypassed around the FIFO.
//  - Arbitration per cycle, where ne = FIFO not empty:
//      load_wins = ne && (!alu_valid || starve_cnt >= STARVE_LIMIT)
//      alu_ready = !(ne && starve_cnt >= STARVE_LIMIT)   (independent of alu_valid)
//  - Update when a write is selected:
//    - ALU selected: rf_* <= {1, alu_rd, alu_data}.
//    - Load selected: rf_* <= {1, head.rd, extend(head)}; dequeue.
//    - Neither selected: rf_write_enable <= 0; address/data hold their values.
//  - starve_cnt:
//    - Cleared on dequeue or when the FIFO is empty.
//    - Incremented when ne && ALU selected.
//    - Saturates at STARVE_LIMIT.
//  - rd == 0: the write is consumed normally, but rf_write_enable <= 0.
//  - Enqueue when ld_valid && ld_ready.
//    - Full: ld_ready = 0. Enqueue and dequeue in the same cycle are legal when not full.
//    - Pointers wrap modulo LD_FIFO_DEPTH; an occupancy counter distinguishes full from empty.
//  - extend(), selected by funct3:
//    - 000 LB  : byte at addr_lo, sign-extended
//    - 100 LBU : byte at addr_lo, zero-extended
//    - 001 LH  : half addr_lo[1], sign-extended
//    - 101 LHU : half addr_lo[1], zero-extended
//    - 010 LW  : full word; addr_lo is ignored
//    - 011, 110, 111 : data = 0 (write still issued)
//    - addr_lo[0] is ignored for halfwords.
// CONFIGURATION
//  WB_PERF_EN defined: adds output ports, all reset to 0 and wrapping on overflow:
//    - perf_alu_wb [31:0]: +1 per ALU write
//    - perf_ld_wb [31:0]: +1 per load write
//    - perf_ld_stall [31:0]: +1 per cycle with ld_valid && !ld_ready
//    - perf_starve [31:0]: +1 per cycle alu_ready is forced low
//  WB_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  - ALU only: alu_rd=5, alu_data=0x1234 for 1 cycle -> next cycle rf_write_enable=1, rd=5, data=0x00001234; after that, enable=0.
//  - rd=0: ALU write with rd=0, data 0xFFFF -> alu_ready=1, rf_write_enable stays 0.
//  - Extension, ld_rdata=0x80F0_7F81:
//    - LB at addr_lo=3 -> 0xFFFFFF80
//    - LBU at addr_lo=0 -> 0x00000081
//    - LH at addr_lo=2 -> 0xFFFF80F0
//    - LHU at addr_lo=0 -> 0x00007F81
//    - LW -> 0x80F07F81
//  - Starvation, STARVE_LIMIT=4: continuous alu_valid, 1 load enqueued ->
//    4 ALU writes, then alu_ready=0 for 1 cycle, load write, then ALU resumes.
//  - Full FIFO, depth 2: 3 back-to-back loads under continuous ALU traffic ->
//    ld_ready=0 after 2 loads, until the first dequeue.
//  - Reset with 2 loads buffered -> no load write after reset deasserts; ld_ready=1; rf_* = 0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: sole register-file writer, merging ALU results and buffered loads.
// Define WB_PERF_EN to add the perf_* writeback/stall counters.
module wb_stage #(
    parameter int LD_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
`ifdef WB_PERF_EN
    output logic [31:0] perf_alu_wb,
    output logic [31:0] perf_ld_wb,
    output logic [31:0] perf_ld_stall,
    output logic [31:0] perf_starve,
`endif
    output logic        rf_write_enable,
    output logic [4:0]  rf_rd_address,
    output logic [31:0] rf_write_data
);

    localparam int AW = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(LD_FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(LD_FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [4:0]    fifo_rd   [LD_FIFO_DEPTH];
    logic [2:0]    fifo_f3   [LD_FIFO_DEPTH];
    logic [1:0]    fifo_lo   [LD_FIFO_DEPTH];
    logic [31:0]   fifo_word [LD_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;

    logic        ne;
    logic        forced;
    logic        alu_sel;
    logic        load_sel;
    logic        enq;
    logic [4:0]  head_rd;
    logic [2:0]  head_f3;
    logic [1:0]  head_lo;
    logic [31:0] head_word;
    logic [7:0]  head_byte;
    logic [15:0] head_half;
    logic [31:0] head_ext;

    assign ne        = (count != '0);
    assign forced    = ne && (starve_cnt >= LIMIT_C);
    assign alu_ready = !forced;
    assign ld_ready  = (count != DEPTH_C);
    assign alu_sel   = alu_valid && !forced;
    // Same as ne && (!alu_valid || forced), but exclusive with alu_sel by construction.
    assign load_sel  = ne && !alu_sel;
    assign enq       = ld_valid && ld_ready;

    assign head_rd   = fifo_rd[rd_ptr];
    assign head_f3   = fifo_f3[rd_ptr];
    assign head_lo   = fifo_lo[rd_ptr];
    assign head_word = fifo_word[rd_ptr];

    always_comb begin
        head_byte = head_word[{head_lo, 3'b000} +: 8];
        head_half = head_lo[1] ? head_word[31:16] : head_word[15:0];
        head_ext  = '0;
        unique case (head_f3)
            3'b000:  head_ext = {{24{head_byte[7]}}, head_byte};
            3'b100:  head_ext = {24'd0, head_byte};
            3'b001:  head_ext = {{16{head_half[15]}}, head_half};
            3'b101:  head_ext = {16'd0, head_half};
            3'b010:  head_ext = head_word;
            default: head_ext = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd[wr_ptr]   <= ld_rd;
            fifo_f3[wr_ptr]   <= ld_funct3;
            fifo_lo[wr_ptr]   <= ld_addr_lo;
            fifo_word[wr_ptr] <= ld_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + AW'(1);
            if (load_sel)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({enq, load_sel})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (load_sel || !ne)
            starve_cnt <= '0;
        else if (alu_sel && starve_cnt != LIMIT_C)
            starve_cnt <= starve_cnt + SW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_write_enable <= 1'b0;
            rf_rd_address   <= '0;
            rf_write_data   <= '0;
        end else begin
            unique case (1'b1)
                alu_sel: begin
                    rf_write_enable <= (alu_rd != 5'd0);
                    rf_rd_address   <= alu_rd;
                    rf_write_data   <= alu_data;
                end
                load_sel: begin
                    rf_write_enable <= (head_rd != 5'd0);
                    rf_rd_address   <= head_rd;
                    rf_write_data   <= head_ext;
                end
                default: rf_write_enable <= 1'b0;
            endcase
        end
    end

`ifdef WB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_alu_wb   <= '0;
            perf_ld_wb    <= '0;
            perf_ld_stall <= '0;
            perf_starve   <= '0;
        end else begin
            if (alu_sel)
                perf_alu_wb <= perf_alu_wb + 32'd1;
            if (load_sel)
                perf_ld_wb <= perf_ld_wb + 32'd1;
            if (ld_valid && !ld_ready)
                perf_ld_stall <= perf_ld_stall + 32'd1;
            if (forced)
                perf_starve <= perf_starve + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: queue-based reference model checked every cycle,
// plus directed literal checks for the documented scenarios.
module tb_wb_stage;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [31:0] ld_rdata;
    logic        rf_write_enable;
    logic [4:0]  rf_rd_address;
    logic [31:0] rf_write_data;
`ifdef WB_PERF_EN
    logic [31:0] perf_alu_wb;
    logic [31:0] perf_ld_wb;
    logic [31:0] perf_ld_stall;
    logic [31:0] perf_starve;
`endif

    always #5 clk = ~clk;

    wb_stage #(.LD_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_rd           (ld_rd),
        .ld_funct3       (ld_funct3),
        .ld_addr_lo      (ld_addr_lo),
        .ld_rdata        (ld_rdata),
`ifdef WB_PERF_EN
        .perf_alu_wb     (perf_alu_wb),
        .perf_ld_wb      (perf_ld_wb),
        .perf_ld_stall   (perf_ld_stall),
        .perf_starve     (perf_starve),
`endif
        .rf_write_enable (rf_write_enable),
        .rf_rd_address   (rf_rd_address),
        .rf_write_data   (rf_write_data)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] w;
    } ld_t;

    ld_t         q[$];
    int          losses = 0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_rd   = '0;
    logic [31:0] m_data = '0;
    int          tests  = 0;
    int          fails  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_extend(input ld_t e);
        logic [31:0] b;
        logic [31:0] h;
        b = (e.w >> (8 * e.lo)) & 32'hFF;
        h = (e.w >> (16 * e.lo[1])) & 32'hFFFF;
        case (e.f3)
            3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            3'd2:    return e.w;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin : model
        int  sz;
        bit  frc;
        ld_t e;
        if (reset) begin
            q.delete();
            losses = 0;
            m_we   = 1'b0;
            m_rd   = '0;
            m_data = '0;
        end else begin
            sz  = q.size();
            frc = (sz > 0) && (losses >= LIMIT);
            if (alu_valid && !frc) begin
                m_we   = (alu_rd != 0);
                m_rd   = alu_rd;
                m_data = alu_data;
                if (sz > 0 && losses < LIMIT)
                    losses = losses + 1;
            end else if (sz > 0) begin
                e      = q.pop_front();
                m_we   = (e.rd != 0);
                m_rd   = e.rd;
                m_data = ref_extend(e);
                losses = 0;
            end else begin
                m_we = 1'b0;
            end
            if (sz == 0)
                losses = 0;
            if (ld_valid && sz < DEPTH) begin
                e.rd = ld_rd;
                e.f3 = ld_funct3;
                e.lo = ld_addr_lo;
                e.w  = ld_rdata;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        chk("alu_ready", 32'(alu_ready),
            32'(!(q.size() > 0 && losses >= LIMIT)));
        chk("ld_ready", 32'(ld_ready), 32'(q.size() < DEPTH));
        chk("rf_we", 32'(rf_write_enable), 32'(m_we));
        if (m_we || reset) begin
            chk("rf_rd", 32'(rf_rd_address), 32'(m_rd));
            chk("rf_data", rf_write_data, m_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid  = 1'b0;
        alu_rd     = '0;
        alu_data   = '0;
        ld_valid   = 1'b0;
        ld_rd      = '0;
        ld_funct3  = '0;
        ld_addr_lo = '0;
        ld_rdata   = '0;
    endtask

    logic [2:0]  ext_f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  ext_lo  [5] = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd1};
    logic [31:0] ext_exp [5] = '{32'hFFFFFF80, 32'h00000081, 32'hFFFF80F0,
                                 32'h00007F81, 32'h80F07F81};

    initial begin
        int n_low;
        reset = 1'b1;
        idle();
        step();
        chk("reset_we", 32'(rf_write_enable), 32'd0);
        chk("reset_rd", 32'(rf_rd_address), 32'd0);
        chk("reset_data", rf_write_data, 32'd0);
        chk("reset_ld_ready", 32'(ld_ready), 32'd1);
        step();
        reset = 1'b0;
        step();

        // single ALU write, then idle
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'h1234;
        step();
        idle();
        chk("alu_we", 32'(rf_write_enable), 32'd1);
        chk("alu_rd", 32'(rf_rd_address), 32'd5);
        chk("alu_data", rf_write_data, 32'h00001234);
        step();
        chk("alu_we_after", 32'(rf_write_enable), 32'd0);

        // rd == 0 is consumed but not written
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'hFFFF;
        #1;
        chk("rd0_alu_ready", 32'(alu_ready), 32'd1);
        step();
        idle();
        chk("rd0_we", 32'(rf_write_enable), 32'd0);

        for (int i = 0; i < 5; i++) begin
            ld_valid   = 1'b1;
            ld_rd      = 5'(10 + i);
            ld_funct3  = ext_f3[i];
            ld_addr_lo = ext_lo[i];
            ld_rdata   = 32'h80F07F81;
            step();
            idle();
            step();
            chk("ext_we", 32'(rf_write_enable), 32'd1);
            chk("ext_rd", 32'(rf_rd_address), 32'(10 + i));
            chk("ext_data", rf_write_data, ext_exp[i]);
        end

        // starvation: one load under continuous ALU traffic
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        alu_data  = 32'h100;
        ld_valid  = 1'b1;
        ld_rd     = 5'd7;
        ld_funct3 = 3'd2;
        ld_rdata  = 32'hCAFE0000;
        step();
        ld_valid = 1'b0;
        chk("starve_first_alu", 32'(rf_rd_address), 32'd1);
        for (int i = 1; i <= LIMIT; i++) begin
            chk("starve_alu_ready", 32'(alu_ready), 32'd1);
            alu_data = 32'(32'h100 + i);
            step();
            chk("starve_alu_rd", 32'(rf_rd_address), 32'd1);
            chk("starve_alu_data", rf_write_data, 32'(32'h100 + i));
        end
        chk("starve_forced", 32'(alu_ready), 32'd0);
        step();
        chk("starve_ld_rd", 32'(rf_rd_address), 32'd7);
        chk("starve_ld_data", rf_write_data, 32'hCAFE0000);
        chk("starve_resume_ready", 32'(alu_ready), 32'd1);
        alu_data = 32'h200;
        step();
        chk("starve_resume_data", rf_write_data, 32'h200);

        // full FIFO: three back-to-back loads, ALU always valid
        ld_valid  = 1'b1;
        ld_funct3 = 3'd2;
        ld_rd     = 5'd20;
        ld_rdata  = 32'hA0A0A0A0;
        chk("full_ready0", 32'(ld_ready), 32'd1);
        step();
        ld_rd    = 5'd21;
        ld_rdata = 32'hA1A1A1A1;
        chk("full_ready1", 32'(ld_ready), 32'd1);
        step();
        ld_rd    = 5'd22;
        ld_rdata = 32'hA2A2A2A2;
        n_low    = 0;
        for (int c = 0; c < 20; c++) begin
            if (ld_ready)
                break;
            n_low++;
            step();
        end
        chk("full_low_cycles", 32'(n_low), 32'd4);
        chk("full_first_deq_rd", 32'(rf_rd_address), 32'd20);
        step();
        ld_valid = 1'b0;

        // reset with two loads buffered
        reset = 1'b1;
        #1;
        chk("rst_mid_ld_ready", 32'(ld_ready), 32'd1);
        step();
        idle();
        step();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("post_rst_we", 32'(rf_write_enable), 32'd0);
            chk("post_rst_rd", 32'(rf_rd_address), 32'd0);
            chk("post_rst_data", rf_write_data, 32'd0);
            chk("post_rst_ld_ready", 32'(ld_ready), 32'd1);
        end

        for (int c = 0; c < 3000; c++) begin
            alu_valid  = ($urandom_range(0, 9) < ((c < 1500) ? 6 : 9));
            alu_rd     = 5'($urandom_range(0, 31));
            alu_data   = $urandom();
            ld_valid   = 1'($urandom_range(0, 1));
            ld_rd      = 5'($urandom_range(0, 31));
            ld_funct3  = 3'($urandom_range(0, 7));
            ld_addr_lo = 2'($urandom_range(0, 3));
            ld_rdata   = $urandom();
            reset      = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
